// File: rtl/sipo_deserializer_rx.sv
// sipo_deserializer_rx: serial-in, parallel-out receiver, LSB first.
//   Assembles N serial bits into a word. The word is presented on a registered
//   valid/ready holding stage. It is ready on the edge that samples the last bit.
//   Backpressure: a word that completes while the holding stage is full and not
//   being consumed is dropped, and the sticky overrun flag is set.
// Optional feature macro: SIPO_RX_PARITY_EN adds a trailing even-parity bit per word.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   bit_en, SI            SI is a valid serial bit when bit_en is high
//   sync                  frame restart, discards any partial word
//   data_out, data_valid  assembled word and its valid flag
//   data_ready            consumer accepts data_out this cycle
//   overrun, overrun_clr  sticky dropped-word flag and its clear
//   busy                  a partial word is in progress
//   parity_err            parity result for the word on data_out (0 without the macro)
module sipo_deserializer_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         bit_en,
  input  logic         SI,
  input  logic         sync,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         overrun,
  input  logic         overrun_clr,
  output logic         busy,
  output logic         parity_err
);

  localparam int CW = $clog2(N + 1);

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_PARITY} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RECV} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [N-1:0]    shift_w;
  logic [N-1:0]    word_w;
  logic            word_done;
  logic            load_w;

  logic [N-1:0]    dout_q, dout_d;
  logic            dvld_q, dvld_d;
  logic            ovr_q, ovr_d;

`ifdef SIPO_RX_PARITY_EN
  logic            par_w;
  logic            perr_q, perr_d;
`endif

  // New bits enter at the MSB, so after N bits the first one sits at bit 0.
  assign shift_w = {SI, shreg_q[N-1:1]};

  // Receive state machine.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    word_w    = shreg_q;
`ifdef SIPO_RX_PARITY_EN
    par_w     = 1'b0;
`endif
    if (sync) begin
      // Restart framing. A bit arriving with sync is bit 0 of the new word.
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (bit_en) begin
        shreg_d = shift_w;
        state_d = ST_RECV;
        cnt_d   = CW'(1);
      end
    end else if (bit_en) begin
      case (state_q)
        ST_IDLE: begin
          shreg_d = shift_w;
          state_d = ST_RECV;
          cnt_d   = CW'(1);
        end
        ST_RECV: begin
          shreg_d = shift_w;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d = '0;
`ifdef SIPO_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d   = ST_IDLE;
            word_done = 1'b1;
            word_w    = shift_w;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SIPO_RX_PARITY_EN
        ST_PARITY: begin
          // The parity bit is not shifted in. The data word is already complete in shreg.
          state_d   = ST_IDLE;
          word_done = 1'b1;
          word_w    = shreg_q;
          par_w     = (^shreg_q) ^ SI;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output holding stage: load when empty or draining on this same edge.
  assign load_w = word_done && (!dvld_q || data_ready);

  always_comb begin
    dout_d = dout_q;
    dvld_d = dvld_q;
    ovr_d  = ovr_q;
`ifdef SIPO_RX_PARITY_EN
    perr_d = perr_q;
`endif
    if (load_w) begin
      dout_d = word_w;
      dvld_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
      perr_d = par_w;
`endif
    end else if (dvld_q && data_ready) begin
      dvld_d = 1'b0;
    end
    // A dropped word takes priority over a clear in the same cycle.
    if (word_done && !load_w) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = dout_q;
  assign data_valid = dvld_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_deserializer_rx.sv
// Testbench for sipo_deserializer_rx: directed scenarios followed by random traffic.
// Each cycle, outputs are compared against a word-level reference model.
module tb_sipo_deserializer_rx;

  localparam int N = 4;
`ifdef SIPO_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         bit_en = 1'b0;
  logic         SI = 1'b0;
  logic         sync = 1'b0;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         overrun;
  logic         overrun_clr = 1'b0;
  logic         busy;
  logic         parity_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: bits collected so far and the partial word they form.
  int           m_idx;
  logic [N-1:0] m_word;
  logic [N-1:0] m_out;
  logic         m_valid;
  logic         m_ovr;
  logic         m_perr;

  sipo_deserializer_rx #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bit_en     (bit_en),
    .SI         (SI),
    .sync       (sync),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_word = '0; m_out = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dout"}, 32'(data_out), 32'(m_out));
    chk({tag, "_valid"}, 32'(data_valid), 32'(m_valid));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_busy"}, 32'(busy), 32'(m_idx != 0));
    chk({tag, "_perr"}, 32'(parity_err), 32'(m_perr));
  endtask

  // One clock cycle. Inputs are driven, the model is advanced, and after the edge the outputs are compared.
  task automatic step(input logic be, input logic si, input logic sy, input logic rdy, input logic clr);
    logic         done;
    logic [N-1:0] w;
    logic         pe;
    done = 1'b0; w = '0; pe = 1'b0;
    bit_en = be; SI = si; sync = sy; data_ready = rdy; overrun_clr = clr;
    if (sy) begin
      m_idx = 0; m_word = '0;
    end
    if (be) begin
      if (m_idx < N) begin
        m_word[m_idx] = si;
        m_idx++;
        if (m_idx == N && !PAR) begin
          done = 1'b1; w = m_word; m_idx = 0; m_word = '0;
        end
      end else begin
        done = 1'b1; w = m_word; pe = (^m_word) ^ si; m_idx = 0; m_word = '0;
      end
    end
    if (done && (!m_valid || rdy)) begin
      m_out = w; m_valid = 1'b1; m_perr = pe;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (done && !(!m_valid || rdy) && !(m_out == w && m_valid && !rdy && 1'b0)) begin
      // completion while holding stage full and not draining
    end
    @(posedge clk);
    #1;
  endtask

  // Send a word LSB first, plus its even parity bit when parity is enabled.
  task automatic send_word(input logic [N-1:0] w, input logic rdy, input string tag);
    for (int i = 0; i < N; i++) begin
      step(1'b1, w[i], 1'b0, rdy, 1'b0);
      check_all(tag);
    end
    if (PAR) begin
      step(1'b1, ^w, 1'b0, rdy, 1'b0);
      check_all(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    bit_en = 1'b0; SI = 1'b0; sync = 1'b0; data_ready = 1'b0; overrun_clr = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Overrun bookkeeping lives here so that the model's drop rule is stated once.
  task automatic stepx(input logic be, input logic si, input logic sy, input logic rdy, input logic clr);
    logic full_blocked;
    logic will_complete;
    full_blocked  = m_valid && !rdy;
    will_complete = be && !sy && (PAR ? (m_idx == N) : (m_idx == N - 1));
    if (sy && be && !PAR && N == 1) will_complete = 1'b1;
    step(be, si, sy, rdy, clr);
    if (will_complete && full_blocked) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: bits 1,0,1,1 with ready high -> 0xD, valid for one cycle
    stepx(1, 1, 0, 1, 0); check_all("t1");
    stepx(1, 0, 0, 1, 0); check_all("t1"); chk("t1_busy2", 32'(busy), 32'd1);
    stepx(1, 1, 0, 1, 0); check_all("t1");
    stepx(1, 1, 0, 1, 0); check_all("t1");
    if (PAR) begin stepx(1, 1, 0, 1, 0); check_all("t1p"); end
    chk("t1_word", 32'(data_out), 32'hD);
    chk("t1_vld", 32'(data_valid), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);
    stepx(0, 0, 0, 1, 0); check_all("t1");
    chk("t1_vld_drop", 32'(data_valid), 32'd0);

    // 2: 0xA held, 0x5 dropped, then drain and clear
    for (int i = 0; i < N + int'(PAR); i++) begin
      stepx(1, (i < N) ? 1'((4'hA >> i) & 1) : 1'b0, 0, 0, 0); check_all("t2a");
    end
    for (int i = 0; i < N + int'(PAR); i++) begin
      stepx(1, (i < N) ? 1'((4'h5 >> i) & 1) : 1'b0, 0, 0, 0); check_all("t2b");
    end
    chk("t2_hold", 32'(data_out), 32'hA);
    chk("t2_ovr", 32'(overrun), 32'd1);
    stepx(0, 0, 0, 1, 0); check_all("t2");
    chk("t2_drain", 32'(data_valid), 32'd0);
    stepx(0, 0, 0, 0, 1); check_all("t2");
    chk("t2_clr", 32'(overrun), 32'd0);

    // 3: partial 1,1 then sync carrying bit 0 = 0, then 1,1,1 -> 0xE
    stepx(1, 1, 0, 1, 0); check_all("t3");
    stepx(1, 1, 0, 1, 0); check_all("t3");
    stepx(1, 0, 1, 1, 0); check_all("t3");
    chk("t3_novld", 32'(data_valid), 32'd0);
    stepx(1, 1, 0, 1, 0); check_all("t3");
    stepx(1, 1, 0, 1, 0); check_all("t3");
    stepx(1, 1, 0, 1, 0); check_all("t3");
    if (PAR) begin stepx(1, 1, 0, 1, 0); check_all("t3p"); end
    chk("t3_word", 32'(data_out), 32'hE);
    stepx(0, 0, 0, 1, 0); check_all("t3");

    // 4: completion on the same edge as a transfer
    for (int i = 0; i < N + int'(PAR); i++) begin
      stepx(1, (i < N) ? 1'((4'h6 >> i) & 1) : 1'b0, 0, 0, 0); check_all("t4a");
    end
    for (int i = 0; i < N + int'(PAR); i++) begin
      stepx(1, (i < N) ? 1'((4'h9 >> i) & 1) : 1'b0, 0, (i == N - 1 + int'(PAR)), 0);
      check_all("t4b");
    end
    chk("t4_word", 32'(data_out), 32'h9);
    chk("t4_vld", 32'(data_valid), 32'd1);
    chk("t4_ovr", 32'(overrun), 32'd0);
    stepx(0, 0, 0, 1, 0); check_all("t4");

    // 5: reset mid-word, then 0x3 with gaps of three idle cycles between bits
    stepx(1, 1, 0, 1, 0); check_all("t5");
    stepx(1, 1, 0, 1, 0); check_all("t5");
    do_reset("t5_rst");
    for (int i = 0; i < N + int'(PAR); i++) begin
      stepx(1, (i < N) ? 1'((4'h3 >> i) & 1) : 1'b0, 0, 1, 0); check_all("t5");
      if (i < N - 1 + int'(PAR)) begin
        for (int g = 0; g < 3; g++) begin stepx(0, 1, 0, 1, 0); check_all("t5g"); end
      end
    end
    chk("t5_word", 32'(data_out), 32'h3);
    stepx(0, 0, 0, 1, 0); check_all("t5");

`ifdef SIPO_RX_PARITY_EN
    // 6: 0xD with good and bad parity. Valid rises only after the parity bit.
    for (int i = 0; i < N; i++) begin stepx(1, 1'((4'hD >> i) & 1), 0, 1, 0); check_all("t6"); end
    chk("t6_wait", 32'(data_valid), 32'd0);
    stepx(1, 1, 0, 1, 0); check_all("t6");
    chk("t6_good", 32'(parity_err), 32'd0);
    for (int i = 0; i < N; i++) begin stepx(1, 1'((4'hD >> i) & 1), 0, 1, 0); check_all("t6"); end
    stepx(1, 0, 0, 1, 0); check_all("t6");
    chk("t6_bad", 32'(parity_err), 32'd1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rnd_rst");
      end else begin
        stepx(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0));
        check_all("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer_rx.md
Name: sipo_deserializer_rx

Overview:
Serial-in, parallel-out receiver. It pairs with the team's right-shifting parallel-load transmitter, which sends its LSB first on SO.
- Collects N serial bits, LSB first, and assembles them into a word.
- Presents the word on a registered valid/ready output holding stage.
- Sits at the receive end of the serial link and feeds the parallel datapath.

Parameters:
N, 4, data word width in bits (N >= 2).

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  reset, asynchronous, active-low
bit_en  input  1  SI is a valid serial bit this cycle
SI  input  1  serial data in, LSB first
sync  input  1  frame restart; discards any partial word
data_out  output  N  assembled parallel word
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  consumer accepts data_out this cycle
overrun  output  1  sticky: a completed word was dropped
overrun_clr  input  1  clears overrun
busy  output  1  partial word in progress (FSM in RECV or PARITY)
parity_err  output  1  parity result for the word on data_out (see Optional Feature)

Behaviour:
- Reset (async, any state, mid-word included):
  - shift register = 0, bit counter = 0, FSM = IDLE.
  - data_out = 0, data_valid = 0, overrun = 0, busy = 0, parity_err = 0.
- Shift rule: on an accepted bit, shreg <= {SI, shreg[N-1:1]}. After N bits, bit 0 received sits at shreg[0].
- FSM states:
  - IDLE: cnt = 0. bit_en -> RECV, cnt = 1.
  - RECV: each bit_en increments cnt. The bit that completes the word (cnt == N-1) produces a word completion and returns to IDLE with cnt = 0.
  - PARITY: exists only with the macro (see Optional Feature).
- Word completion, with W = {SI, shreg[N-1:1]}:
  - If data_valid == 0, or data_ready == 1 in the same cycle: data_out <= W, data_valid <= 1 at that edge. Latency is 0 cycles after the edge sampling the last bit.
  - If data_valid == 1 and data_ready == 0: W is discarded, data_out is unchanged, overrun <= 1.
- Handshake:
  - A transfer occurs on the edge where data_valid && data_ready.
  - data_valid falls after a transfer unless a new word loads on the same edge; in that case it stays 1 with the new data.
  - data_out is stable while data_valid && !data_ready.
- sync:
  - Forces cnt = 0 and FSM to IDLE; the partial word is discarded.
  - sync && bit_en in the same cycle: SI is taken as bit 0 of a new word (FSM -> RECV, cnt = 1).
  - sync never affects data_out, data_valid or overrun.
- overrun:
  - Set by a dropped word. Cleared by overrun_clr.
  - Set and clear in the same cycle: set wins.
- bit_en == 0: shreg, cnt and FSM hold. Gaps of any length between bits are legal.
- busy = (FSM != IDLE).
- cnt width is clog2(N+1).

Optional Feature:
Macro SIPO_RX_PARITY_EN.
- Defined:
  - After the N-th data bit the FSM enters PARITY instead of completing the word.
  - The next accepted bit is an even-parity bit over the N data bits.
  - Word completion happens on that bit, using the same load/overrun rules as above.
  - parity_err <= (^data ^ parity bit), registered together with data_out. It holds with data_out and is 0 when no word has loaded.
  - sync in PARITY discards the word.
- Not defined: the PARITY state is absent and parity_err is tied to 0.

Test Plan:
1. N=4, reset, send bits 1,0,1,1 (bit 0 first) with bit_en each cycle, data_ready=1 -> data_out=4'hD, data_valid=1 for exactly one cycle after the 4th bit's edge; busy high during bits 2-4 and low after.
2. Send 0xA with data_ready=0, then 0x5 -> data_out stays 0xA, overrun=1; raise data_ready -> transfer, data_valid=0; pulse overrun_clr -> overrun=0.
3. Send bits 1,1, assert sync with bit_en and SI=0, then send 1,1,1 -> data_out=4'hE; no word from the partial frame.
4. Word completes with data_valid=1 and data_ready=1 on the same edge -> old word transferred, new word loaded, data_valid stays 1, overrun=0.
5. Assert reset_n low mid-word after 2 bits, release, send 0x3 -> data_out=4'h3, no residue; bit_en gaps of 3 cycles between bits give the same result.
6. SIPO_RX_PARITY_EN: send 0xD with parity bit 1 -> parity_err=0; send 0xD with parity bit 0 -> parity_err=1; data_valid asserts only after the parity bit.
